ps2_key_event_rx: RTL

//  Parametrised PS/2 keyboard receiver: frames raw PS/2 bits and checks start/parity/stop.

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_key_event_rx_if.sv | 8 +
 rtl/ps2_frame_rx.sv | 52 +++++
 rtl/ps2_key_event_rx.sv | 58 +++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared set-2 prefix codes, frame length and key event type.
package ps2_pkg;
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;
  typedef struct packed {
    logic ext;
    logic brk;
    logic [7:0] code;
  } key_event_t;
endpackage

// File: rtl/ps2_key_event_rx_if.sv
// ps2_key_event_rx_if: key event stream plus sticky status and error clear.
interface ps2_key_event_rx_if #(parameter int FIFO_DEPTH = 8);
  logic valid, ready, brk, ext, overflow, frame_err, clr_err;
  logic [7:0] code;
  logic [$clog2(FIFO_DEPTH):0] count;
  modport master(output valid, code, brk, ext, count, overflow, frame_err, input ready, clr_err);
  modport slave(input valid, code, brk, ext, count, overflow, frame_err, output ready, clr_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the PS/2 pins, frames 11 bits and checks start/parity/stop.
module ps2_frame_rx import ps2_pkg::*; #(
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       err
);
  logic [SYNC_STAGES-1:0] ck_s, dt_s;
  logic ck_q, fall, last, ok, tmo_hit, dt;
  logic [3:0] cnt;
  logic [9:0] sr;
  assign dt = dt_s[SYNC_STAGES-1];
  assign fall = ck_q & ~ck_s[SYNC_STAGES-1];
  assign last = fall && cnt == 4'(PS2_FRAME_BITS - 1);
  // sr[0]=start, sr[8:1]=byte, sr[9]=parity once ten bits are in; dt is the stop bit
  assign ok = ~sr[0] & dt & ^sr[9:1];
  assign byte_valid = last & ok;
  assign data = sr[8:1];
  assign err = (last & ~ok) | tmo_hit;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      ck_s <= '1;
      dt_s <= '1;
      ck_q <= 1'b1;
      cnt <= '0;
      sr <= '0;
    end else begin
      ck_s <= {ck_s[SYNC_STAGES-2:0], ps2_clk};
      dt_s <= {dt_s[SYNC_STAGES-2:0], ps2_data};
      ck_q <= ck_s[SYNC_STAGES-1];
      if (fall) begin
        sr <= {dt, sr[9:1]};
        cnt <= last ? '0 : cnt + 4'd1;
      end else if (tmo_hit) cnt <= '0;
    end
  if (TIMEOUT_CYC > 0) begin : g_tmo
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo;
    always_ff @(posedge clk or negedge clrn)
      if (!clrn) tmo <= '0;
      else tmo <= (fall || cnt == 4'd0) ? '0 : tmo + TW'(1);
    assign tmo_hit = cnt != 4'd0 && !fall && tmo == TW'(TIMEOUT_CYC - 1);
  end else begin : g_no_tmo
    assign tmo_hit = 1'b0;
  end
endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 set-2 receiver decoding E0/F0 prefixes into key events buffered in a FIFO.
module ps2_key_event_rx import ps2_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_key_event_rx_if.master ev
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE = 2'b00, BRK = 2'b01, EXT = 2'b10, EXT_BRK = 2'b11} dec_st_t;
  dec_st_t st;
  key_event_t mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [7:0] b;
  logic bv, ferr, emit, full, push, pop, overflow, frame_err;
  ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)) u_frame (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_valid(bv), .data(b), .err(ferr)
  );
  assign emit = bv && b != PS2_PFX_EXT && b != PS2_PFX_BRK;
  assign full = cnt == CW'(FIFO_DEPTH);
  assign pop = ev.valid && ev.ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push = emit && (!full || pop);
  assign ev.valid = cnt != '0;
  assign {ev.ext, ev.brk, ev.code} = mem[rp];
  assign ev.count = cnt;
  assign ev.overflow = overflow;
  assign ev.frame_err = frame_err;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      st <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      // st[1] tracks E0 and st[0] tracks F0 so either prefix order lands in EXT_BRK
      if (bv) st <= b == PS2_PFX_EXT ? (st[0] ? EXT_BRK : EXT) :
                    b == PS2_PFX_BRK ? (st[1] ? EXT_BRK : BRK) : IDLE;
      if (push) begin
        mem[wp] <= '{ext: st[1], brk: st[0], code: b};
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      overflow <= (emit && full && !pop) | (overflow & ~ev.clr_err);
      frame_err <= ferr | (frame_err & ~ev.clr_err);
    end
endmodule
